// File: rtl/signed_div_if.sv
// Handshake and operand/result bundle for signed_div.
// The divider takes the slave modport; the operand source/result sink takes master.
interface signed_div_if #(
   parameter int unsigned WORD_LEN = 8
);
   logic                i_valid;
   logic                o_ready;
   logic [WORD_LEN-1:0] i_dividend;
   logic [WORD_LEN-1:0] i_divisor;
   logic                o_valid;
   logic                i_ready;
   logic [WORD_LEN-1:0] o_quotient;
   logic [WORD_LEN-1:0] o_remainder;
   logic                o_div_by_zero;

   modport slave (
      input  i_valid, i_dividend, i_divisor, i_ready,
      output o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
   );

   modport master (
      output i_valid, i_dividend, i_divisor, i_ready,
      input  o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
   );
endinterface

// File: rtl/signed_div.sv
// Sequential signed divider: radix-2 restoring iteration on magnitudes, one quotient bit/cycle.
// Optional macro SIGNED_DIV_EARLY_EXIT_EN shortcuts operations where |divisor| > |dividend|.
module signed_div #(
   parameter int unsigned WORD_LEN = 8
) (
   input logic         i_clk,
   input logic         i_srst,
   signed_div_if.slave bus
);
   localparam int unsigned CntW = $clog2(WORD_LEN);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [WORD_LEN-1:0] rem_q, rem_d;
   logic [WORD_LEN-1:0] quo_q, quo_d;
   logic [WORD_LEN-1:0] dvs_q, dvs_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic                dbz_q, dbz_d;
   logic [WORD_LEN-1:0] quot_out_q, quot_out_d;
   logic [WORD_LEN-1:0] rmd_out_q, rmd_out_d;
   logic                dbz_out_q, dbz_out_d;

   logic [WORD_LEN-1:0] dvd_mag, dvs_mag;
   logic [WORD_LEN:0]   shifted, trial;

   assign dvd_mag = bus.i_dividend[WORD_LEN-1] ? -bus.i_dividend : bus.i_dividend;
   assign dvs_mag = bus.i_divisor[WORD_LEN-1]  ? -bus.i_divisor  : bus.i_divisor;

   // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
   assign shifted = {rem_q, quo_q[WORD_LEN-1]};
   assign trial   = shifted - {1'b0, dvs_q};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      dbz_d      = dbz_q;
      quot_out_d = quot_out_q;
      rmd_out_d  = rmd_out_q;
      dbz_out_d  = dbz_out_q;

      unique case (state_q)
         StIdle: begin
            if (bus.i_valid) begin
               neg_quo_d = bus.i_dividend[WORD_LEN-1] ^ bus.i_divisor[WORD_LEN-1];
               neg_rem_d = bus.i_dividend[WORD_LEN-1];
               dvs_d     = dvs_mag;
               cnt_d     = '0;
               rem_d     = '0;
               quo_d     = dvd_mag;
               dbz_d     = (bus.i_divisor == '0);
               if (bus.i_divisor == '0) begin
                  // Remainder magnitude re-signed in StFix reproduces the raw dividend.
                  rem_d   = dvd_mag;
                  state_d = StFix;
               end
`ifdef SIGNED_DIV_EARLY_EXIT_EN
               else if (dvs_mag > dvd_mag) begin
                  // Preload so a single trial (always failing) leaves q=0, r=|dividend|.
                  rem_d   = {1'b0, dvd_mag[WORD_LEN-1:1]};
                  quo_d   = {dvd_mag[0], {(WORD_LEN-1){1'b0}}};
                  cnt_d   = CntW'(WORD_LEN - 1);
                  state_d = StCalc;
               end
`endif
               else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            if (!trial[WORD_LEN]) begin
               rem_d = trial[WORD_LEN-1:0];
               quo_d = {quo_q[WORD_LEN-2:0], 1'b1};
            end else begin
               rem_d = shifted[WORD_LEN-1:0];
               quo_d = {quo_q[WORD_LEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WORD_LEN - 1)) begin
               cnt_d   = '0;
               state_d = StFix;
            end
         end
         StFix: begin
            quot_out_d = dbz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
            rmd_out_d  = neg_rem_q ? -rem_q : rem_q;
            dbz_out_d  = dbz_q;
            state_d    = StDone;
         end
         StDone: begin
            if (bus.i_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dbz_q      <= 1'b0;
         quot_out_q <= '0;
         rmd_out_q  <= '0;
         dbz_out_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         dbz_q      <= dbz_d;
         quot_out_q <= quot_out_d;
         rmd_out_q  <= rmd_out_d;
         dbz_out_q  <= dbz_out_d;
      end
   end

   assign bus.o_ready       = (state_q == StIdle);
   assign bus.o_valid       = (state_q == StDone);
   assign bus.o_quotient    = quot_out_q;
   assign bus.o_remainder   = rmd_out_q;
   assign bus.o_div_by_zero = dbz_out_q;
endmodule
